multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencing controller for the RV32I core. Steps each instruction through FETCH, DECODE, EXEC, MEM and WB. Drives the enables and mux selects for the PC register, instruction register, register file, ALU and data memory. Waits on a data-memory ready handshake and bounds the wait with a timeout. Stops in a sticky TRAP state on an unsupported encoding or a memory timeout.

## Interface
- WAIT_LIMIT, 15: maximum cycles spent in MEM waiting for mem_ready before a timeout trap (range 1..255).
- clk  in  1  core clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- ir  in  32  instruction register contents (opcode [6:0], funct3 [14:12], funct7 [31:25]).
- alu_zero  in  1  ALU result == 0; sampled in EXEC.
- mem_ready  in  1  data memory has completed the current access.
- pc_write  out  1  load the PC register.
- pc_src  out  2  0 = pc+4, 1 = branch target, 2 = jal target.
- ir_write  out  1  load the instruction register from instruction memory.
- reg_write  out  1  register file write enable.
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC (link), 3 = U-immediate.
- alu_src_b  out  1  0 = rs2, 1 = immediate.
- alu_op  out  2  0 = add, 1 = subtract/compare, 2 = use funct3/funct7.
- mem_read, mem_write  out  1 each  data memory strobes.
- retire  out  1  one-cycle pulse when an instruction completes.
- trap  out  1  sticky; 1 while in TRAP.
- trap_cause  out  2  0 = none, 1 = illegal instruction, 2 = memory timeout.

## Operation
- Supported opcodes:
  - R-ALU 0110011; funct7 must be 0000000, or 0100000 with funct3 000 or 101.
  - I-ALU 0010011.
  - LOAD 0000011 and STORE 0100011; funct3 010 only.
  - BRANCH 1100011; funct3 000 (BEQ) or 001 (BNE).
  - JAL 1101111.
  - LUI 0110111.
  - Anything else, including the all-zero word, is illegal.
- FETCH: assert ir_write=1, pc_write=1, pc_src=0. Next state DECODE.
- DECODE: no strobes. If ir is illegal, go to TRAP with cause 1; otherwise go to EXEC.
- EXEC, per opcode:
  - R/I-ALU: alu_op=2; alu_src_b=0 for R, 1 for I. Next WB.
  - LOAD/STORE: alu_op=0, alu_src_b=1. Next MEM.
  - BRANCH: alu_op=1, alu_src_b=0. Taken if (BEQ and alu_zero) or (BNE and !alu_zero). Taken: pc_write=1, pc_src=1. Always retire=1, next FETCH.
  - JAL: reg_write=1, wb_sel=2, pc_write=1, pc_src=2, retire=1. Next FETCH.
  - LUI: next WB.
- MEM:
  - Assert mem_read for a load or mem_write for a store every cycle until mem_ready=1.
  - When mem_ready=1: a load goes to WB; a store asserts retire and goes to FETCH.
  - Wait counter clears on MEM entry and increments each cycle mem_ready=0. When it reaches WAIT_LIMIT with mem_ready still 0, go to TRAP with cause 2.
  - If mem_ready and the limit coincide, mem_ready wins.
- WB: reg_write=1 and retire=1. wb_sel is 0 for ALU ops, 1 for load, 3 for LUI. Next FETCH.
- TRAP: every enable and strobe is 0; trap=1; trap_cause held. Exit only via rst.
- Opcode and funct fields are taken from ir on every cycle. ir is stable from DECODE onward because ir_write is asserted only in FETCH.

## Timing
- All outputs are a function of registered state plus ir, alu_zero and mem_ready. No output is registered beyond the state.
- While rst=1, every output is 0. On the first rising edge with rst=0, state is FETCH.
- Reset in any state, including MEM mid-wait or TRAP, returns to FETCH next cycle and clears the wait counter and trap_cause.
- Cycles per instruction, with mem_ready high on MEM entry:
  - BRANCH and JAL: 3.
  - R-ALU, I-ALU, LUI and STORE: 4.
  - LOAD: 5.
  - Each mem_ready=0 cycle in MEM adds one.
- retire is exactly one cycle per instruction, on that instruction's final cycle.
- mem_read/mem_write never assert outside MEM. pc_write never asserts in DECODE, MEM or WB.

## Structure
- Shared package cpu_pkg:
  - state_t enum (FETCH, DECODE, EXEC, MEM, WB, TRAP).
  - Opcode localparams.
  - pc_src_t, wb_sel_t, alu_op_t and trap_cause_t enums.
  - cpu_pkg is also consumed by the datapath muxes.
- One combinational sub-module, rv32i_opcode_decode: maps ir to an instruction class plus a legal flag. The FSM and wait counter stay in multicycle_control.

## Test plan
- Reset, then ir=0x005303b3 (add x7,x6,x5): FETCH, DECODE, EXEC with alu_op=2, WB with reg_write=1 and wb_sel=0; retire pulses on cycle 4; pc_write only in cycle 1.
- ir=0x00000000 after reset: trap=1 and trap_cause=1 from cycle 3. All strobes stay 0 for 20 cycles; rst then restarts at FETCH.
- BEQ (0x00628463): with alu_zero=1, EXEC has pc_write=1 and pc_src=1. With alu_zero=0, pc_write=0. Both cases retire in 3 cycles.
- LW (0x0002a303) with mem_ready low for 3 cycles: mem_read high 4 cycles, then WB with wb_sel=1. Total 8 cycles.
- SW (0x0062a023) with WAIT_LIMIT=15 and mem_ready never high: mem_write high 15 cycles, then trap_cause=2 and mem_write=0.
- rst asserted during the 2nd MEM wait cycle of a load: all outputs 0 during reset; FETCH with ir_write=1 on the first cycle after release; the next instruction still gets the full WAIT_LIMIT wait.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the RV32I multi-cycle core: controller states, opcodes,
// datapath mux selects and the decoded instruction class.
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, TRAP
  } state_t;

  localparam logic [6:0] OP_R_ALU  = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JAL    = 2'd2
  } pc_src_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2,
    WB_UIMM = 2'd3
  } wb_sel_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_TIMEOUT = 2'd2
  } trap_cause_t;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_R_ALU, CLS_I_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_LUI
  } inst_class_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: instruction/status inputs to the controller
// and the enables and mux selects it drives back.
interface multicycle_control_if;
  import cpu_pkg::*;

  logic [31:0] ir;
  logic        alu_zero;
  logic        mem_ready;

  logic        pc_write;
  pc_src_t     pc_src;
  logic        ir_write;
  logic        reg_write;
  wb_sel_t     wb_sel;
  logic        alu_src_b;
  alu_op_t     alu_op;
  logic        mem_read;
  logic        mem_write;
  logic        retire;
  logic        trap;
  trap_cause_t trap_cause;

  modport master (
    input  ir, alu_zero, mem_ready,
    output pc_write, pc_src, ir_write, reg_write, wb_sel, alu_src_b, alu_op,
           mem_read, mem_write, retire, trap, trap_cause
  );

  modport slave (
    output ir, alu_zero, mem_ready,
    input  pc_write, pc_src, ir_write, reg_write, wb_sel, alu_src_b, alu_op,
           mem_read, mem_write, retire, trap, trap_cause
  );

endinterface

// File: rtl/rv32i_opcode_decode.sv
// Classifies an RV32I instruction word into the subset this core executes;
// anything outside that subset comes out as CLS_NONE / legal=0.
module rv32i_opcode_decode
  import cpu_pkg::*;
(
  input  logic [31:0] ir,
  output inst_class_t cls,
  output logic        legal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = ir[6:0];
  assign funct3        = ir[14:12];
  assign funct7        = ir[31:25];
  assign unused_fields = ^{ir[24:15], ir[11:7]};

  always_comb begin
    // NOTE: default first so every path assigns cls and no latch is inferred.
    cls = CLS_NONE;
    case (opcode)
      OP_R_ALU: begin
        // Only SUB and SRA use the alternate funct7 encoding.
        if (funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
          cls = CLS_R_ALU;
      end
      OP_I_ALU:  cls = CLS_I_ALU;
      OP_LOAD:   if (funct3 == 3'b010) cls = CLS_LOAD;
      OP_STORE:  if (funct3 == 3'b010) cls = CLS_STORE;
      OP_BRANCH: if (funct3 == 3'b000 || funct3 == 3'b001) cls = CLS_BRANCH;
      OP_JAL:    cls = CLS_JAL;
      OP_LUI:    cls = CLS_LUI;
      default:   cls = CLS_NONE;
    endcase
  end

  assign legal = (cls != CLS_NONE);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the RV32I core: FETCH/DECODE/EXEC/MEM/WB with a
// bounded data-memory wait and a sticky TRAP state left only through rst.
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_control_if.master  bus
);

  localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

  state_t      state, next_state;
  trap_cause_t cause_q, next_cause;
  logic [7:0]  wait_cnt;
  inst_class_t cls;
  logic        legal;
  logic        br_taken;
  logic        at_limit;

  rv32i_opcode_decode u_decode (
    .ir    (bus.ir),
    .cls   (cls),
    .legal (legal)
  );

  // funct3[0] separates BNE from BEQ once the decoder has accepted the branch.
  assign br_taken = bus.ir[12] ? !bus.alu_zero : bus.alu_zero;
  assign at_limit = (wait_cnt == LIMIT_M1);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (rst) begin
      state    <= FETCH;
      cause_q  <= CAUSE_NONE;
      wait_cnt <= '0;
    end else begin
      state   <= next_state;
      cause_q <= next_cause;
      // Held at zero outside MEM so each MEM entry starts a fresh wait.
      if (state == MEM && !bus.mem_ready) wait_cnt <= wait_cnt + 8'd1;
      else                                wait_cnt <= '0;
    end
  end

  always_comb begin
    next_state = state;
    next_cause = cause_q;
    case (state)
      FETCH:  next_state = DECODE;
      DECODE: begin
        if (legal) next_state = EXEC;
        else begin
          next_state = TRAP;
          next_cause = CAUSE_ILLEGAL;
        end
      end
      EXEC: begin
        case (cls)
          CLS_R_ALU, CLS_I_ALU, CLS_LUI: next_state = WB;
          CLS_LOAD, CLS_STORE:           next_state = MEM;
          default:                       next_state = FETCH;
        endcase
      end
      MEM: begin
        if (bus.mem_ready) next_state = (cls == CLS_LOAD) ? WB : FETCH;
        else if (at_limit) begin
          next_state = TRAP;
          next_cause = CAUSE_TIMEOUT;
        end
      end
      WB:      next_state = FETCH;
      TRAP:    next_state = TRAP;
      default: next_state = FETCH;
    endcase
  end

  // Outputs are forced low while rst is high, whatever state is still held.
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.pc_src     = PC_PLUS4;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.wb_sel     = WB_ALU;
    bus.alu_src_b  = 1'b0;
    bus.alu_op     = ALU_ADD;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.retire     = 1'b0;
    bus.trap       = 1'b0;
    bus.trap_cause = CAUSE_NONE;
    if (!rst) begin
      case (state)
        FETCH: begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
        end
        EXEC: begin
          case (cls)
            CLS_R_ALU: bus.alu_op = ALU_FUNCT;
            CLS_I_ALU: begin
              bus.alu_op    = ALU_FUNCT;
              bus.alu_src_b = 1'b1;
            end
            CLS_LOAD, CLS_STORE: bus.alu_src_b = 1'b1;
            CLS_BRANCH: begin
              bus.alu_op = ALU_SUB;
              bus.retire = 1'b1;
              if (br_taken) begin
                bus.pc_write = 1'b1;
                bus.pc_src   = PC_BRANCH;
              end
            end
            CLS_JAL: begin
              bus.reg_write = 1'b1;
              bus.wb_sel    = WB_LINK;
              bus.pc_write  = 1'b1;
              bus.pc_src    = PC_JAL;
              bus.retire    = 1'b1;
            end
            default: ;
          endcase
        end
        MEM: begin
          bus.mem_read  = (cls == CLS_LOAD);
          bus.mem_write = (cls == CLS_STORE);
          bus.retire    = bus.mem_ready && (cls == CLS_STORE);
        end
        WB: begin
          bus.reg_write = 1'b1;
          bus.retire    = 1'b1;
          bus.wb_sel    = (cls == CLS_LOAD) ? WB_MEM :
                          (cls == CLS_LUI)  ? WB_UIMM : WB_ALU;
        end
        TRAP: begin
          bus.trap       = 1'b1;
          bus.trap_cause = cause_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: builds a per-cycle table of stimulus and expected
// outputs from instruction-level rules, then replays and compares it.
module tb_multicycle_control;
  import cpu_pkg::*;

  localparam int WAIT_LIMIT = 15;

  localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LD = 3, K_ST = 4,
                 K_BR = 5, K_JAL = 6, K_LUI = 7;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       retire;
    logic       trap;
    logic [1:0] trap_cause;
  } outs_t;

  typedef struct {
    logic        rst;
    logic [31:0] ir;
    logic        alu_zero;
    logic        mem_ready;
    outs_t       exp;
    string       tag;
  } row_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_if bus();

  multicycle_control #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  row_t rows[$];
  int   cpi_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic int classify(input logic [31:0] w);
    logic [6:0] op = w[6:0];
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    case (op)
      7'h33: return (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) ? K_R : K_ILL;
      7'h13: return K_I;
      7'h03: return (f3 == 3'd2) ? K_LD : K_ILL;
      7'h23: return (f3 == 3'd2) ? K_ST : K_ILL;
      7'h63: return (f3 <= 3'd1) ? K_BR : K_ILL;
      7'h6f: return K_JAL;
      7'h37: return K_LUI;
      default: return K_ILL;
    endcase
  endfunction

  function automatic void push(input logic r, input logic [31:0] w, input logic z,
                               input logic rdy, input outs_t e, input string tag);
    row_t x;
    x.rst = r; x.ir = w; x.alu_zero = z; x.mem_ready = rdy; x.exp = e; x.tag = tag;
    rows.push_back(x);
  endfunction

  function automatic void add_reset(input int n);
    outs_t e = '0;
    repeat (n) push(1'b1, 32'h0, 1'b0, 1'b0, e, "reset");
  endfunction

  // waits < 0: memory never answers. abort_at >= 0: rst replaces that MEM wait cycle.
  function automatic void add_instr(input logic [31:0] w, input logic z, input int waits,
                                    input int trap_rows, input int abort_at);
    int    k = classify(w);
    int    n_low;
    outs_t e;
    e = '0; e.ir_write = 1'b1; e.pc_write = 1'b1;
    push(1'b0, w, z, 1'b0, e, "fetch");
    e = '0;
    push(1'b0, w, z, 1'b0, e, "decode");
    if (k == K_ILL) begin
      e = '0; e.trap = 1'b1; e.trap_cause = 2'd1;
      repeat (trap_rows) push(1'b0, w, z, 1'b0, e, "trap_illegal");
      return;
    end
    e = '0;
    case (k)
      K_R: e.alu_op = 2'd2;
      K_I: begin e.alu_op = 2'd2; e.alu_src_b = 1'b1; end
      K_LD, K_ST: e.alu_src_b = 1'b1;
      K_BR: begin
        e.alu_op = 2'd1;
        e.retire = 1'b1;
        if ((w[14:12] == 3'd0) ? z : !z) begin e.pc_write = 1'b1; e.pc_src = 2'd1; end
      end
      K_JAL: begin
        e.reg_write = 1'b1; e.wb_sel = 2'd2; e.pc_write = 1'b1; e.pc_src = 2'd2; e.retire = 1'b1;
      end
      default: ;
    endcase
    push(1'b0, w, z, 1'b0, e, "exec");
    if (k == K_BR || k == K_JAL) return;
    if (k == K_LD || k == K_ST) begin
      e = '0; e.mem_read = (k == K_LD); e.mem_write = (k == K_ST);
      n_low = (waits < 0) ? WAIT_LIMIT : waits;
      for (int i = 0; i < n_low; i++) begin
        if (i == abort_at) begin add_reset(2); return; end
        push(1'b0, w, z, 1'b0, e, "mem_wait");
      end
      if (waits < 0) begin
        e = '0; e.trap = 1'b1; e.trap_cause = 2'd2;
        repeat (trap_rows) push(1'b0, w, z, 1'b0, e, "trap_timeout");
        return;
      end
      e.retire = (k == K_ST);
      push(1'b0, w, z, 1'b1, e, "mem_ready");
      if (k == K_ST) return;
    end
    e = '0; e.reg_write = 1'b1; e.retire = 1'b1;
    e.wb_sel = (k == K_LD) ? 2'd1 : (k == K_LUI) ? 2'd3 : 2'd0;
    push(1'b0, w, z, 1'b0, e, "wb");
  endfunction

  function automatic outs_t get_outs();
    outs_t o;
    o.pc_write = bus.pc_write;   o.pc_src = bus.pc_src;       o.ir_write = bus.ir_write;
    o.reg_write = bus.reg_write; o.wb_sel = bus.wb_sel;       o.alu_src_b = bus.alu_src_b;
    o.alu_op = bus.alu_op;       o.mem_read = bus.mem_read;   o.mem_write = bus.mem_write;
    o.retire = bus.retire;       o.trap = bus.trap;           o.trap_cause = bus.trap_cause;
    return o;
  endfunction

  initial begin
    outs_t act;
    int    cyc = 0, start = 0, got, want;
    bit    started = 0;
    rst = 1'b1; bus.ir = '0; bus.alu_zero = 1'b0; bus.mem_ready = 1'b0;

    add_reset(2);
    add_instr(32'h005303b3, 1'b0, 0, 0, -1); cpi_q.push_back(4);   // add
    add_instr(32'h00628463, 1'b1, 0, 0, -1); cpi_q.push_back(3);   // beq taken
    add_instr(32'h00628463, 1'b0, 0, 0, -1); cpi_q.push_back(3);   // beq not taken
    add_instr(32'h00629463, 1'b0, 0, 0, -1); cpi_q.push_back(3);   // bne taken
    add_instr(32'h0002a303, 1'b0, 3, 0, -1); cpi_q.push_back(8);   // lw, 3 waits
    add_instr(32'h0062a023, 1'b0, 0, 0, -1); cpi_q.push_back(4);   // sw
    add_instr(32'h123452b7, 1'b0, 0, 0, -1); cpi_q.push_back(4);   // lui
    add_instr(32'h008000ef, 1'b0, 0, 0, -1); cpi_q.push_back(3);   // jal
    add_instr(32'h00130313, 1'b0, 0, 0, -1); cpi_q.push_back(4);   // addi
    add_instr(32'h40628333, 1'b0, 0, 0, -1); cpi_q.push_back(4);   // sub
    add_instr(32'h0002a303, 1'b0, 14, 0, -1); cpi_q.push_back(19); // ready on the limit cycle
    add_instr(32'h00000000, 1'b0, 0, 20, -1);                      // all-zero word
    add_reset(2);
    add_instr(32'h40629333, 1'b0, 0, 3, -1);                       // bad funct7/funct3
    add_reset(1);
    add_instr(32'h00028303, 1'b0, 0, 3, -1);                       // lb not supported
    add_reset(1);
    add_instr(32'h0062a023, 1'b0, -1, 4, -1);                      // sw timeout
    add_reset(2);
    add_instr(32'h0002a303, 1'b0, -1, 0, 1);                       // lw hit by rst
    add_instr(32'h0002a303, 1'b0, -1, 3, -1);                      // full wait again
    add_reset(1);
    add_instr(32'h005303b3, 1'b0, 0, 0, -1); cpi_q.push_back(4);

    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk);
      #1;
      rst = rows[i].rst; bus.ir = rows[i].ir;
      bus.alu_zero = rows[i].alu_zero; bus.mem_ready = rows[i].mem_ready;
      @(negedge clk);
      cyc++;
      act = get_outs();
      vectors++;
      if (act !== rows[i].exp) begin
        miscompares++;
        $display("FAIL %s row %0d: outputs got %h want %h", rows[i].tag, i, act, rows[i].exp);
      end
      if (rows[i].rst) started = 0;
      else begin
        if (act.ir_write === 1'b1) begin start = cyc; started = 1; end
        if (act.retire === 1'b1) begin
          vectors++;
          if (!started || cpi_q.size() == 0) begin
            miscompares++;
            $display("FAIL cpi row %0d: unexpected retire", i);
          end else begin
            got  = cyc - start + 1;
            want = cpi_q.pop_front();
            if (got != want) begin
              miscompares++;
              $display("FAIL cpi row %0d: cycles got %0d want %0d", i, got, want);
            end
          end
        end
      end
    end

    vectors++;
    if (cpi_q.size() != 0) begin
      miscompares++;
      $display("FAIL retire_count: %0d instructions never retired", cpi_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
